udp_rx: RTL and testbench

GMII-side UDP/IPv4 frame receiver; the receive counterpart of the board's UDP transmitter. Parses preamble, Ethernet header, IPv4 header and UDP header from the byte stream, filters on board MAC/IP, and delivers the UDP payload to the user side. Payload is delivered as big-endian 32-bit words with a per-frame completion pulse and byte count. FCS is not checked; trailing pad and FCS bytes are discarded.

---
 rtl/udp_pkg.sv | 33 +++
 rtl/udp_rx_if.sv | 19 +
 rtl/ip_csum_chk.sv | 39 +++
 rtl/udp_rx.sv | 196 +++++++++++++++++++
 tb/tb_udp_rx.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/udp_pkg.sv
// Shared UDP/IPv4 framing constants, the rx parser state enum and byte-select helpers.
package udp_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        ETH_HEAD,
        IP_HEAD,
        UDP_HEAD,
        RX_DATA,
        RX_END
    } rx_state_t;

    // Byte idx of a big-endian field, idx 0 being the first byte on the wire.
    function automatic logic [7:0] be_byte48(input logic [47:0] v, input logic [2:0] idx);
        logic [47:0] s;
        s = v << (8 * idx);
        return s[47:40];
    endfunction

    function automatic logic [7:0] be_byte32(input logic [31:0] v, input logic [1:0] idx);
        logic [31:0] s;
        s = v << (8 * idx);
        return s[31:24];
    endfunction

endpackage

// File: rtl/udp_rx_if.sv
// GMII receive byte stream plus the user-side payload word/strobe bus of udp_rx.
interface udp_rx_if;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        rec_en;
    logic [31:0] rec_data;
    logic        rec_pkt_done;
    logic [15:0] rec_byte_num;

    modport master (
        output gmii_rx_dv, gmii_rxd,
        input  rec_en, rec_data, rec_pkt_done, rec_byte_num
    );

    modport slave (
        input  gmii_rx_dv, gmii_rxd,
        output rec_en, rec_data, rec_pkt_done, rec_byte_num
    );
endinterface

// File: rtl/ip_csum_chk.sv
// Streaming IPv4 header checksum: pairs bytes into 16-bit words and keeps a
// one's-complement running sum; sum_ok is high when the folded sum is 16'hFFFF.
module ip_csum_chk (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       sum_ok
);
    logic [15:0] acc_reg;
    logic [7:0]  hi_reg;
    logic        odd_reg;
    logic [16:0] sum;

    assign sum    = {1'b0, acc_reg} + {1'b0, hi_reg, byte_data};
    assign sum_ok = (acc_reg == 16'hFFFF);

    // End-around carry is folded on every add, so the sum never needs a final pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= 16'h0000;
            hi_reg  <= 8'h00;
            odd_reg <= 1'b0;
        end else if (clear) begin
            acc_reg <= 16'h0000;
            hi_reg  <= 8'h00;
            odd_reg <= 1'b0;
        end else if (byte_valid) begin
            if (!odd_reg) begin
                hi_reg  <= byte_data;
                odd_reg <= 1'b1;
            end else begin
                acc_reg <= sum[15:0] + {15'd0, sum[16]};
                odd_reg <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/udp_rx.sv
// GMII UDP/IPv4 receiver: filters on board MAC/IP and streams the payload as big-endian words.
// Optional IP header checksum verification when UDP_RX_IP_CSUM_EN is defined.
module udp_rx
    import udp_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h99_00_33_11_00_00,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
    input  logic     clk,
    input  logic     rst_n,
    udp_rx_if.slave  bus
);
    rx_state_t   state_reg;
    logic [15:0] cnt_reg;
    logic [3:0]  ihl_reg;
    logic        mac_board_reg;
    logic        mac_bcast_reg;
    logic [7:0]  len_hi_reg;
    logic [15:0] udp_len_reg;
    logic [15:0] pay_len_reg;
    logic [31:0] word_reg;

    logic        rec_en_reg;
    logic [31:0] rec_data_reg;
    logic        rec_pkt_done_reg;
    logic [15:0] rec_byte_num_reg;

    logic        dv;
    logic [7:0]  rxd;
    logic [5:0]  ip_idx;
    logic [5:0]  ip_last;
    logic [1:0]  lane;
    logic        mac_board_next;
    logic        mac_bcast_next;
    logic        eth_bad;
    logic        ip_bad;
    logic        last_byte;
    logic        csum_ok;
    logic [31:0] word_asm;

    assign dv        = bus.gmii_rx_dv;
    assign rxd       = bus.gmii_rxd;
    assign ip_idx    = cnt_reg[5:0];
    assign ip_last   = {ihl_reg, 2'b00} - 6'd1;
    assign lane      = cnt_reg[1:0];
    assign last_byte = (cnt_reg == (pay_len_reg - 16'd1));

    assign bus.rec_en       = rec_en_reg;
    assign bus.rec_data     = rec_data_reg;
    assign bus.rec_pkt_done = rec_pkt_done_reg;
    assign bus.rec_byte_num = rec_byte_num_reg;

    // Lanes beyond the current byte read as zero, so a short final word is zero-padded.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign word_asm[31-8*gi -: 8] = (lane == 2'(gi)) ? rxd :
                                            (lane >  2'(gi)) ? word_reg[31-8*gi -: 8] : 8'h00;
        end
    endgenerate

`ifdef UDP_RX_IP_CSUM_EN
    ip_csum_chk u_csum (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state_reg == ETH_HEAD),
        .byte_valid ((state_reg == IP_HEAD) && dv),
        .byte_data  (rxd),
        .sum_ok     (csum_ok)
    );
`else
    assign csum_ok = 1'b1;
`endif

    always_comb begin
        mac_board_next = ((cnt_reg == 16'd0) || mac_board_reg) &&
                         (rxd == be_byte48(BOARD_MAC, cnt_reg[2:0]));
        mac_bcast_next = ((cnt_reg == 16'd0) || mac_bcast_reg) &&
                         (rxd == be_byte48(BCAST_MAC, cnt_reg[2:0]));
        eth_bad = ((cnt_reg == 16'd5)  && !mac_board_next && !mac_bcast_next) ||
                  ((cnt_reg == 16'd12) && (rxd != ETH_TYPE_IPV4[15:8])) ||
                  ((cnt_reg == 16'd13) && (rxd != ETH_TYPE_IPV4[7:0]));
        ip_bad  = ((ip_idx == 6'd0) && ((rxd[7:4] != 4'h4) || (rxd[3:0] < 4'd5))) ||
                  ((ip_idx == 6'd9) && (rxd != IP_PROTO_UDP)) ||
                  ((ip_idx >= 6'd16) && (ip_idx <= 6'd19) &&
                   (rxd != be_byte32(BOARD_IP, ip_idx[1:0])));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= 16'd0;
            ihl_reg          <= 4'd0;
            mac_board_reg    <= 1'b0;
            mac_bcast_reg    <= 1'b0;
            len_hi_reg       <= 8'd0;
            udp_len_reg      <= 16'd0;
            pay_len_reg      <= 16'd0;
            word_reg         <= 32'd0;
            rec_en_reg       <= 1'b0;
            rec_data_reg     <= 32'd0;
            rec_pkt_done_reg <= 1'b0;
            rec_byte_num_reg <= 16'd0;
        end else begin
            rec_en_reg       <= 1'b0;
            rec_pkt_done_reg <= 1'b0;
            if (!dv) begin
                state_reg <= IDLE;
                cnt_reg   <= 16'd0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (rxd == PREAMBLE_BYTE) begin
                            state_reg <= PREAMBLE;
                            cnt_reg   <= 16'd1;
                        end
                    end
                    PREAMBLE: begin
                        if ((rxd == PREAMBLE_BYTE) && (cnt_reg < 16'd7)) begin
                            cnt_reg <= cnt_reg + 16'd1;
                        end else if ((rxd == SFD_BYTE) && (cnt_reg >= 16'd6)) begin
                            state_reg <= ETH_HEAD;
                            cnt_reg   <= 16'd0;
                        end else begin
                            state_reg <= RX_END;
                        end
                    end
                    ETH_HEAD: begin
                        cnt_reg <= cnt_reg + 16'd1;
                        if (cnt_reg < 16'd6) begin
                            mac_board_reg <= mac_board_next;
                            mac_bcast_reg <= mac_bcast_next;
                        end
                        if (eth_bad) begin
                            state_reg <= RX_END;
                        end else if (cnt_reg == 16'd13) begin
                            state_reg <= IP_HEAD;
                            cnt_reg   <= 16'd0;
                        end
                    end
                    IP_HEAD: begin
                        cnt_reg <= cnt_reg + 16'd1;
                        if (ip_idx == 6'd0) begin
                            ihl_reg <= rxd[3:0];
                        end
                        if (ip_bad) begin
                            state_reg <= RX_END;
                        end else if ((ip_idx != 6'd0) && (ip_idx == ip_last)) begin
                            state_reg <= UDP_HEAD;
                            cnt_reg   <= 16'd0;
                        end
                    end
                    UDP_HEAD: begin
                        cnt_reg <= cnt_reg + 16'd1;
                        if (cnt_reg == 16'd4) begin
                            len_hi_reg <= rxd;
                        end
                        if (cnt_reg == 16'd5) begin
                            udp_len_reg <= {len_hi_reg, rxd};
                        end
                        if (cnt_reg == 16'd7) begin
                            if (!csum_ok || (udp_len_reg < 16'd8)) begin
                                state_reg <= RX_END;
                            end else if (udp_len_reg == 16'd8) begin
                                rec_pkt_done_reg <= 1'b1;
                                rec_byte_num_reg <= 16'd0;
                                state_reg        <= RX_END;
                            end else begin
                                pay_len_reg <= udp_len_reg - 16'd8;
                                state_reg   <= RX_DATA;
                                cnt_reg     <= 16'd0;
                            end
                        end
                    end
                    RX_DATA: begin
                        cnt_reg  <= cnt_reg + 16'd1;
                        word_reg <= word_asm;
                        if ((lane == 2'd3) || last_byte) begin
                            rec_en_reg   <= 1'b1;
                            rec_data_reg <= word_asm;
                        end
                        if (last_byte) begin
                            rec_pkt_done_reg <= 1'b1;
                            rec_byte_num_reg <= pay_len_reg;
                            state_reg        <= RX_END;
                        end
                    end
                    RX_END: begin
                        state_reg <= RX_END;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_udp_rx.sv
// Table-driven bench for udp_rx: builds complete GMII frames, collects the strobes and
// compares against hand-computed words, done pulses and byte counts.
module tb_udp_rx;
    localparam logic [47:0] B_MAC = 48'h99_00_33_11_00_00;
    localparam logic [31:0] B_IP  = {8'd192, 8'd168, 8'd1, 8'd10};

    typedef struct {
        logic [47:0] mac;
        logic [31:0] ip;
        logic [7:0]  proto;
        int          ihl;
        int          npre;
        int          plen;
        logic [63:0] pay;
        int          pad;
        bit          bad_csum;
        int          exp_words;
        logic [63:0] exp_w;
        int          exp_done;
        logic [15:0] exp_num;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    udp_rx_if bus ();

    udp_rx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #4 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [7:0]  frm[$];
    logic [31:0] got_w[$];
    int          got_done;
    logic        done_with_en;
    vec_t        tbl[12];

    always @(negedge clk) begin
        if (bus.rec_en) got_w.push_back(bus.rec_data);
        if (bus.rec_pkt_done) begin
            got_done     = got_done + 1;
            done_with_en = bus.rec_en;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    function automatic vec_t mk(input logic [47:0] mac, input logic [31:0] ip, input logic [7:0] proto,
                                input int ihl, input int npre, input int plen, input logic [63:0] pay,
                                input int pad, input bit bad, input int ew, input logic [63:0] w,
                                input int ed, input logic [15:0] num);
        vec_t v;
        v.mac = mac; v.ip = ip; v.proto = proto; v.ihl = ihl; v.npre = npre; v.plen = plen;
        v.pay = pay; v.pad = pad; v.bad_csum = bad; v.exp_words = ew; v.exp_w = w;
        v.exp_done = ed; v.exp_num = num;
        return v;
    endfunction

    task automatic build(input vec_t v);
        logic [7:0]  iph[$];
        int          tot;
        int          ulen;
        logic [31:0] s;
        logic [15:0] cs;
        frm.delete();
        repeat (v.npre) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        for (int i = 0; i < 6; i++) frm.push_back(v.mac[47-8*i -: 8]);
        frm.push_back(8'h02);
        repeat (4) frm.push_back(8'h00);
        frm.push_back(8'h01);
        frm.push_back(8'h08);
        frm.push_back(8'h00);
        tot  = v.ihl * 4 + 8 + v.plen;
        ulen = 8 + v.plen;
        iph.push_back(8'h40 | 8'(v.ihl));
        iph.push_back(8'h00);
        iph.push_back(tot[15:8]);
        iph.push_back(tot[7:0]);
        iph.push_back(8'h12); iph.push_back(8'h34);
        iph.push_back(8'h40); iph.push_back(8'h00);
        iph.push_back(8'h40); iph.push_back(v.proto);
        iph.push_back(8'h00); iph.push_back(8'h00);
        iph.push_back(8'd192); iph.push_back(8'd168); iph.push_back(8'd1); iph.push_back(8'd2);
        for (int i = 0; i < 4; i++) iph.push_back(v.ip[31-8*i -: 8]);
        for (int i = 0; i < (v.ihl - 5) * 4; i++) iph.push_back(8'h00);
        s = 32'd0;
        for (int i = 0; i < iph.size(); i += 2) s = s + {16'd0, iph[i], iph[i+1]};
        s  = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s  = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        cs = ~s[15:0];
        if (v.bad_csum) cs = cs ^ 16'h0001;
        iph[10] = cs[15:8];
        iph[11] = cs[7:0];
        foreach (iph[i]) frm.push_back(iph[i]);
        frm.push_back(8'h04); frm.push_back(8'hD2);
        frm.push_back(8'h1F); frm.push_back(8'h90);
        frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h00);
        for (int i = 0; i < v.plen; i++) frm.push_back(v.pay[63-8*i -: 8]);
        repeat (v.pad) frm.push_back(8'h00);
        frm.push_back(8'hDE); frm.push_back(8'hAD); frm.push_back(8'hBE); frm.push_back(8'hEF);
    endtask

    task automatic clear_mon();
        got_w.delete();
        got_done     = 0;
        done_with_en = 1'b0;
    endtask

    // Drives the first n bytes of frm, then holds a minimum inter-frame gap.
    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.gmii_rx_dv = 1'b1;
            bus.gmii_rxd   = frm[i];
        end
        @(posedge clk); #1;
        bus.gmii_rx_dv = 1'b0;
        bus.gmii_rxd   = 8'h00;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        clear_mon();
        build(v);
        send(frm.size());
        chk($sformatf("v%0d nwords", idx), got_w.size(), v.exp_words);
        for (int i = 0; i < v.exp_words && i < got_w.size(); i++)
            chk($sformatf("v%0d word%0d", idx, i), got_w[i], v.exp_w[63-32*i -: 32]);
        chk($sformatf("v%0d ndone", idx), got_done, v.exp_done);
        chk($sformatf("v%0d byte_num", idx), {16'd0, bus.rec_byte_num}, {16'd0, v.exp_num});
        if (v.exp_done == 1 && v.exp_words > 0)
            chk($sformatf("v%0d done_with_en", idx), {31'd0, done_with_en}, 32'd1);
    endtask

    initial begin
        bus.gmii_rx_dv = 1'b0;
        bus.gmii_rxd   = 8'h00;
        clear_mon();

        tbl[0]  = mk(B_MAC, B_IP, 8'd17, 5, 7, 4, 64'h11223344_00000000, 14, 0,
                     1, 64'h11223344_00000000, 1, 16'd4);
        tbl[1]  = mk(B_MAC, B_IP, 8'd17, 5, 7, 6, 64'h11223344_55660000, 12, 0,
                     2, 64'h11223344_55660000, 1, 16'd6);
        tbl[2]  = mk(48'h00_11_22_33_44_55, B_IP, 8'd17, 5, 7, 4, 64'h11223344_00000000, 14, 0,
                     0, 64'h0, 0, 16'd6);
        tbl[3]  = mk(48'hFFFF_FFFF_FFFF, B_IP, 8'd17, 5, 7, 3, 64'hAABBCC00_00000000, 15, 0,
                     1, 64'hAABBCC00_00000000, 1, 16'd3);
        tbl[4]  = mk(B_MAC, {8'd192, 8'd168, 8'd1, 8'd11}, 8'd17, 5, 7, 4, 64'h11223344_00000000, 14, 0,
                     0, 64'h0, 0, 16'd3);
        tbl[5]  = mk(B_MAC, B_IP, 8'd6, 5, 7, 4, 64'h11223344_00000000, 14, 0,
                     0, 64'h0, 0, 16'd3);
        tbl[6]  = mk(B_MAC, B_IP, 8'd17, 6, 7, 4, 64'hDEADBEEF_00000000, 10, 0,
                     1, 64'hDEADBEEF_00000000, 1, 16'd4);
        tbl[7]  = mk(B_MAC, B_IP, 8'd17, 5, 6, 5, 64'h01020304_05000000, 13, 0,
                     2, 64'h01020304_05000000, 1, 16'd5);
        tbl[8]  = mk(B_MAC, B_IP, 8'd17, 5, 5, 4, 64'h11223344_00000000, 14, 0,
                     0, 64'h0, 0, 16'd5);
        tbl[9]  = mk(B_MAC, B_IP, 8'd17, 5, 7, 0, 64'h0, 18, 0,
                     0, 64'h0, 1, 16'd0);
`ifdef UDP_RX_IP_CSUM_EN
        tbl[10] = mk(B_MAC, B_IP, 8'd17, 5, 7, 2, 64'h77880000_00000000, 16, 1,
                     0, 64'h0, 0, 16'd0);
`else
        tbl[10] = mk(B_MAC, B_IP, 8'd17, 5, 7, 2, 64'h77880000_00000000, 16, 1,
                     1, 64'h77880000_00000000, 1, 16'd2);
`endif
        tbl[11] = mk(B_MAC, B_IP, 8'd17, 5, 7, 8, 64'h01020304_05060708, 10, 0,
                     2, 64'h01020304_05060708, 1, 16'd8);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset rec_en", {31'd0, bus.rec_en}, 32'd0);
        chk("reset rec_data", bus.rec_data, 32'd0);
        chk("reset rec_pkt_done", {31'd0, bus.rec_pkt_done}, 32'd0);
        chk("reset rec_byte_num", {16'd0, bus.rec_byte_num}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 12; i++) run_vec(i, tbl[i]);

        // dv drops after 2 payload bytes: nothing completes, byte count holds.
        clear_mon();
        build(tbl[0]);
        send(7 + 1 + 14 + 20 + 8 + 2);
        chk("drop nwords", got_w.size(), 0);
        chk("drop ndone", got_done, 0);
        chk("drop byte_num", {16'd0, bus.rec_byte_num}, 32'd8);
        run_vec(20, tbl[0]);

        // Reset asserted inside the IP header.
        clear_mon();
        build(tbl[1]);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            bus.gmii_rx_dv = 1'b1;
            bus.gmii_rxd   = frm[i];
        end
        @(posedge clk); #1;
        rst_n          = 1'b0;
        bus.gmii_rx_dv = 1'b0;
        bus.gmii_rxd   = 8'h00;
        @(negedge clk);
        chk("midrst rec_data", bus.rec_data, 32'd0);
        chk("midrst rec_byte_num", {16'd0, bus.rec_byte_num}, 32'd0);
        chk("midrst rec_en", {31'd0, bus.rec_en}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        run_vec(21, tbl[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
